// File: rtl/mavg_filter_pkg.sv
// mavg_filter_pkg
// Shared constants for the moving-average filter slice: default sizing and
// the fill-state encoding used by the top-level control logic.
// No ports (package only).
package mavg_filter_pkg;

  localparam int DEFAULT_W     = 32;
  localparam int DEFAULT_DEPTH = 8;

  // Fill-state encoding: FILLING until DEPTH samples have been seen, then STEADY.
  localparam logic [0:0] ST_FILLING = 1'b0;
  localparam logic [0:0] ST_STEADY  = 1'b1;

endpackage

// File: rtl/mavg_ring.sv
// mavg_ring
// DEPTH x W sample ring with a wrapping write pointer. The entry at the write
// pointer (the oldest sample, or zero while the window is still filling) is
// exposed so the caller can subtract it from a running sum in the same edge
// that overwrites it.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   clr      in   synchronous clear of all entries and the write pointer
//   wr_en    in   write wr_data at the pointer and advance it
//   wr_data  in   W-bit sample to store
//   old_data out  W-bit entry currently at the write pointer
module mavg_ring
  import mavg_filter_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] old_data
);

  localparam int L = $clog2(DEPTH);

  logic [W-1:0] ring [DEPTH];
  logic [L-1:0] wptr;

  // DEPTH is a power of two, so the pointer wraps DEPTH-1 -> 0 by overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      wptr <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      wptr <= '0;
    end else if (wr_en) begin
      ring[wptr] <= wr_data;
      wptr       <= wptr + 1'b1;
    end
  end

  assign old_data = ring[wptr];

endmodule

// File: rtl/mavg_filter.sv
// mavg_filter
// Moving-window accumulator/averager over the last DEPTH accepted samples.
// Keeps a full-precision running sum (W+L bits, cannot overflow) and presents
// the floor average sum >>> L. y_valid pulses for one cycle after each
// accepted sample once the window is full.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   clr      in   synchronous clear; wins over en
//   en       in   accept x on this edge (when clr=0)
//   x        in   W-bit signed sample
//   sum      out  W+L-bit signed window sum
//   y        out  W-bit signed floor average
//   y_valid  out  one-cycle pulse after an accept with the window full
//   full     out  DEPTH samples accepted since reset/clear
module mavg_filter
  import mavg_filter_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic signed [W-1:0]   x,
  output logic signed [W+$clog2(DEPTH)-1:0] sum,
  output logic signed [W-1:0]   y,
  output logic                  y_valid,
  output logic                  full
);

  localparam int L  = $clog2(DEPTH);
  localparam int SW = W + L;
  localparam logic [L:0] LAST_FILL = (L+1)'(DEPTH - 1);

  logic              accept;
  logic [W-1:0]      old_data;
  logic signed [SW-1:0] x_ext;
  logic signed [SW-1:0] old_ext;
  logic [L:0]        count;
  logic [0:0]        state;

  assign accept  = en & ~clr;
  assign x_ext   = {{L{x[W-1]}}, x};
  assign old_ext = {{L{old_data[W-1]}}, old_data};

  mavg_ring #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .wr_en    (accept),
    .wr_data  (x),
    .old_data (old_data)
  );

  // Running sum, fill counter and fill state. The oldest entry is zero while
  // filling, so the same add/subtract works in both states. The accept that
  // completes the window already produces a valid average.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum     <= '0;
      count   <= '0;
      state   <= ST_FILLING;
      full    <= 1'b0;
      y_valid <= 1'b0;
    end else if (clr) begin
      sum     <= '0;
      count   <= '0;
      state   <= ST_FILLING;
      full    <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      if (en) begin
        sum <= sum + x_ext - old_ext;
        case (state)
          ST_FILLING: begin
            count <= count + 1'b1;
            if (count == LAST_FILL) begin
              state   <= ST_STEADY;
              full    <= 1'b1;
              y_valid <= 1'b1;
            end
          end
          ST_STEADY: y_valid <= 1'b1;
          default:   state   <= ST_FILLING;
        endcase
      end
    end
  end

  // Dropping the low L bits of a two's-complement sum is an arithmetic shift,
  // which rounds toward minus infinity.
  assign y = sum[SW-1:L];

endmodule

// File: tb/tb_mavg_filter.sv
// tb_mavg_filter
// Self-checking bench for mavg_filter (W=32, DEPTH=8) plus a DEPTH=2 instance.
// A queue-based window model predicts sum/y/y_valid/full every cycle; literal
// expectations pin the directed scenarios.
module tb_mavg_filter;

  localparam int W     = 32;
  localparam int DEPTH = 8;
  localparam int L     = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic en  = 1'b0;
  logic signed [W-1:0]   x = '0;
  logic signed [W+L-1:0] sum;
  logic signed [W-1:0]   y;
  logic                  y_valid;
  logic                  full;

  logic clr2 = 1'b0;
  logic en2  = 1'b0;
  logic signed [W-1:0] x2 = '0;
  logic signed [W:0]   sum2;
  logic signed [W-1:0] y2;
  logic                y_valid2;
  logic                full2;

  int     tests  = 0;
  int     fails  = 0;
  bit     cmp_on = 1'b0;
  longint win[$];
  bit     m_valid = 1'b0;

  mavg_filter #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .x(x),
    .sum(sum), .y(y), .y_valid(y_valid), .full(full)
  );

  mavg_filter #(.W(W), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .clr(clr2), .en(en2), .x(x2),
    .sum(sum2), .y(y2), .y_valid(y_valid2), .full(full2)
  );

  always #5 clk = ~clk;

  // Window model: the last DEPTH accepted samples since reset/clear.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      win.delete();
      m_valid = 1'b0;
    end else if (clr) begin
      win.delete();
      m_valid = 1'b0;
    end else if (en) begin
      win.push_back(longint'(x));
      if (win.size() > DEPTH) void'(win.pop_front());
      m_valid = (win.size() == DEPTH);
    end else begin
      m_valid = 1'b0;
    end
  end

  function automatic longint modelSum();
    longint s = 0;
    foreach (win[i]) s += win[i];
    return s;
  endfunction

  task automatic checkField(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input longint e_sum, input longint e_y,
                             input longint e_valid, input longint e_full);
    checkField({name, ".sum"},     longint'(sum),     e_sum);
    checkField({name, ".y"},       longint'(y),       e_y);
    checkField({name, ".y_valid"}, longint'(y_valid), e_valid);
    checkField({name, ".full"},    longint'(full),    e_full);
  endtask

  task automatic applyStimulus(input logic e, input logic c, input logic signed [W-1:0] v);
    en  = e;
    clr = c;
    x   = v;
    @(posedge clk);
    #1;
  endtask

  // Every-cycle comparison against the window model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      longint s;
      s = modelSum();
      checkField("model.sum",     longint'(sum),     s);
      checkField("model.y",       longint'(y),       s >>> L);
      checkField("model.y_valid", longint'(y_valid), longint'(m_valid));
      checkField("model.full",    longint'(full),    longint'(win.size() == DEPTH));
    end
  end

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    checkOutput("reset", 0, 0, 0, 0);
    cmp_on = 1'b1;

    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b0, 10);
      if (i < 8) checkField("fill.y_valid", longint'(y_valid), 0);
    end
    checkOutput("fill8", 80, 10, 1, 1);

    applyStimulus(1'b1, 1'b0, -6);
    checkOutput("first_evict", 64, 8, 1, 1);
    repeat (7) applyStimulus(1'b1, 1'b0, -6);
    checkOutput("wrap", -48, -6, 1, 1);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("hold", -48, -6, 0, 1);

    en2 = 1'b1;
    x2  = 3;
    @(posedge clk);
    #1;
    x2  = 4;
    @(posedge clk);
    #1;
    en2 = 1'b0;
    checkField("d2.sum",     longint'(sum2),     7);
    checkField("d2.y",       longint'(y2),       3);
    checkField("d2.y_valid", longint'(y_valid2), 1);
    checkField("d2.full",    longint'(full2),    1);

    applyStimulus(1'b0, 1'b1, 0);
    checkOutput("clear", 0, 0, 0, 0);
    repeat (7) applyStimulus(1'b1, 1'b0, -1);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("floor", -6, -1, 1, 1);

    applyStimulus(1'b0, 1'b1, 0);
    repeat (8) applyStimulus(1'b1, 1'b0, 32'h7FFF_FFFF);
    checkOutput("max_pos", 64'sd17179869176, 64'sd2147483647, 1, 1);
    repeat (8) applyStimulus(1'b1, 1'b0, 32'h8000_0000);
    checkOutput("max_neg", -64'sd17179869184, -64'sd2147483648, 1, 1);

    applyStimulus(1'b0, 1'b1, 0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 1'b0, 5);
      checkOutput("gap_acc", 5 * k, (5 * k) / 8, 0, 0);
      for (int g = 0; g < 3; g++) begin
        applyStimulus(1'b0, 1'b0, 5);
        checkOutput("gap_hold", 5 * k, (5 * k) / 8, 0, 0);
      end
    end

    applyStimulus(1'b0, 1'b1, 0);
    repeat (4) applyStimulus(1'b1, 1'b0, 1);
    checkOutput("pre_clr", 4, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 99);
    checkOutput("clr_wins", 0, 0, 0, 0);
    repeat (5) applyStimulus(1'b1, 1'b0, 2);
    checkOutput("pre_rst", 10, 1, 0, 0);
    en = 1'b1;
    x  = 2;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b0, 3);
      if (i < 8) checkField("refill.y_valid", longint'(y_valid), 0);
    end
    checkOutput("refill8", 24, 3, 1, 1);

    for (int i = 0; i < 400; i++) begin
      logic signed [W-1:0] v;
      v = (($urandom_range(0, 3) == 0) ? $signed($urandom()) : $signed(W'($urandom_range(0, 200)) - 32'sd100));
      applyStimulus(($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0), v);
    end

    applyStimulus(1'b0, 1'b0, 0);
    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
